// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared definitions for the array-multiplier datapath slice.
//   - state_t       : product accumulator FSM states (ACCUM, HOLD)
//   - *_DEF         : default widths/group size used by prod_accumulator
//   - clog2()       : constant ceiling-log2 used for parameter width checks
package mult_pkg;

    localparam int unsigned PW_DEF   = 8;   // 4x4 array multiplier product width
    localparam int unsigned NACC_DEF = 4;   // products per accumulation group
    localparam int unsigned AW_DEF   = 10;  // accumulated sum width
    localparam int unsigned CW_DEF   = 3;   // group count width

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Smallest r such that 2**r >= v (clog2(0) = clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(v))) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Single-bit full-adder cell.
//   Ports: i_a, i_b  - addend bits
//          i_ci      - carry in
//          o_s       - sum bit
//          o_co      - carry out
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    logic w_ab;

    assign w_ab = i_a ^ i_b;
    assign o_s  = w_ab ^ i_ci;
    assign o_co = (i_a & i_b) | (w_ab & i_ci);

endmodule

// File: rtl/half_adder.sv
// half_adder
//   Single-bit half-adder cell.
//   Ports: i_a, i_b  - addend bits
//          o_s       - sum bit
//          o_co      - carry out
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b;
    assign o_co = i_a & i_b;

endmodule

// File: rtl/rca_adder.sv
// rca_adder
//   W-bit ripple-carry adder built from half/full-adder cells.
//   Bit 0 uses a half adder (no carry in); bits 1..W-1 use full adders.
//   Ports: i_a, i_b  - W-bit unsigned addends
//          o_sum     - W-bit sum
//          o_co      - carry out of the top bit
module rca_adder #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_co
);

    // w_c[k] is the carry into bit k.
    logic [W:1] w_c;

    half_adder u_ha0 (
        .i_a  (i_a[0]),
        .i_b  (i_b[0]),
        .o_s  (o_sum[0]),
        .o_co (w_c[1])
    );

    for (genvar g = 1; g < W; g++) begin : g_fa
        full_adder u_fa (
            .i_a  (i_a[g]),
            .i_b  (i_b[g]),
            .i_ci (w_c[g]),
            .o_s  (o_sum[g]),
            .o_co (w_c[g+1])
        );
    end

    assign o_co = w_c[W];

endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator
//   Accumulates NACC consecutive products (or fewer when flushed) taken over a
//   valid/ready input port and presents the registered group sum and product
//   count on a valid/ready output port.
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     in_valid/in_ready     - product handshake; in_ready = !out_valid || out_ready
//     in_prod [PW]          - unsigned product, sampled only on accept
//     flush                 - close the current non-empty group early
//     out_valid/out_ready   - result handshake
//     out_sum [AW]          - sum of the completed group
//     out_count [CW]        - products in the completed group (1..NACC)
module prod_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned PW   = PW_DEF,
    parameter int unsigned NACC = NACC_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count
);

    if (NACC < 2) begin : g_bad_nacc
        $error("prod_accumulator: NACC must be >= 2");
    end
    if (AW < PW + clog2(NACC)) begin : g_bad_aw
        $error("prod_accumulator: AW too narrow for NACC products of PW bits");
    end
    if (CW < clog2(NACC + 1)) begin : g_bad_cw
        $error("prod_accumulator: CW too narrow to hold NACC");
    end

    state_t        r_state;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_out_sum;
    logic [CW-1:0] r_out_count;

    logic [AW-1:0] w_prod_ext;
    logic [AW-1:0] w_sum;
    logic          w_carry;
    logic          w_accept;
    logic          w_last;
    logic [CW-1:0] w_cnt_inc;

    assign w_prod_ext = {{(AW-PW){1'b0}}, in_prod};

    // r_acc is always zero in HOLD, so the same adder output serves both the
    // running sum in ACCUM and the first product of a group started in HOLD.
    rca_adder #(.W(AW)) u_add (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_co  (w_carry)
    );

    assign out_valid = (r_state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CW'(NACC - 1));
    assign w_cnt_inc = r_cnt + CW'(1);
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_last || flush) begin
                            r_out_sum   <= w_sum;
                            r_out_count <= w_cnt_inc;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_state     <= HOLD;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (flush && (r_cnt != '0)) begin
                        r_out_sum   <= r_acc;
                        r_out_count <= r_cnt;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (w_accept && flush) begin
                            // Drain and close a one-product group in the same
                            // cycle: stay in HOLD with the new result.
                            r_out_sum   <= w_sum;
                            r_out_count <= w_cnt_inc;
                        end else begin
                            r_state <= ACCUM;
                            if (w_accept) begin
                                r_acc <= w_sum;
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // AW is wide enough for NACC full-scale products, so the top carry is dead.
    a_no_carry: assert property (@(posedge clk) disable iff (!rst_n) !w_carry);

endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator
//   Self-checking bench for prod_accumulator: a table of directed vectors,
//   hand-written multi-cycle sequences, and a random soak, all checked
//   against a behavioural model with a result scoreboard queue.
module tb_prod_accumulator;

    localparam int unsigned PW   = 8;
    localparam int unsigned NACC = 4;
    localparam int unsigned AW   = 10;
    localparam int unsigned CW   = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_prod   = '0;
    logic          flush     = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;

    always #5 clk = ~clk;

    prod_accumulator #(
        .PW   (PW),
        .NACC (NACC),
        .AW   (AW),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    typedef struct {
        int unsigned sum;
        int unsigned cnt;
    } res_t;

    typedef struct {
        bit iv;
        int prod;
        bit fl;
        bit ordy;
        bit ev;
        int esum;
        int ecnt;
    } vec_t;

    res_t sb[$];
    vec_t tbl[$];

    int unsigned m_acc;
    int unsigned m_cnt;
    bit          m_valid;
    int          n_checks;
    int          n_errors;
    int unsigned tot_in;
    int unsigned tot_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_result();
        res_t r;
        r.sum = m_acc;
        r.cnt = m_cnt;
        sb.push_back(r);
        m_valid = 1'b1;
        m_acc   = 0;
        m_cnt   = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, update the model
    // for what happens at the rising edge, then check outputs just after it.
    task automatic step(input bit iv, input int prod, input bit fl, input bit ordy);
        bit acc;
        @(negedge clk);
        in_valid  = iv;
        in_prod   = PW'(prod);
        flush     = fl;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, (!m_valid || ordy));
        acc = iv && (!m_valid || ordy);
        if (m_valid && ordy) begin
            tot_out += out_sum;
            check("count_range", (out_count >= 1 && out_count <= NACC), 1);
            if (sb.size() > 0) void'(sb.pop_front());
            m_valid = 1'b0;
        end
        if (acc) begin
            tot_in += prod;
            m_acc  += prod;
            m_cnt++;
            if (m_cnt == NACC || fl) push_result();
        end else if (fl && m_cnt > 0) begin
            push_result();
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid && sb.size() > 0) begin
            check("out_sum", out_sum, sb[0].sum);
            check("out_count", out_count, sb[0].cnt);
        end
    endtask

    task automatic add(input bit iv, input int prod, input bit fl, input bit ordy,
                       input bit ev, input int esum, input int ecnt);
        vec_t v;
        v.iv = iv; v.prod = prod; v.fl = fl; v.ordy = ordy;
        v.ev = ev; v.esum = esum; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_acc    = 0;
        m_cnt    = 0;
        m_valid  = 1'b0;
        tot_in   = 0;
        tot_out  = 0;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        #11 rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed vectors: iv, prod, flush, out_ready, expected valid/sum/count
        add(1, 225, 0, 1, 0,   0, 0);
        add(1, 225, 0, 1, 0,   0, 0);
        add(1, 225, 0, 1, 0,   0, 0);
        add(1, 225, 0, 1, 1, 900, 4);  // full group
        add(0,   0, 0, 1, 0,   0, 0);
        add(1,  10, 0, 1, 0,   0, 0);
        add(1,  20, 0, 1, 0,   0, 0);
        add(0,   0, 1, 1, 1,  30, 2);  // flush alone
        add(0,   0, 0, 1, 0,   0, 0);
        add(0,   0, 1, 1, 0,   0, 0);  // flush on empty group ignored
        add(0,   0, 0, 1, 0,   0, 0);
        add(1,   3, 0, 1, 0,   0, 0);
        add(1,   5, 1, 1, 1,   8, 2);  // flush with a product
        add(0,   0, 0, 1, 0,   0, 0);
        add(1,   1, 0, 1, 0,   0, 0);
        add(1,   1, 0, 1, 0,   0, 0);
        add(1,   1, 0, 1, 0,   0, 0);
        add(1,   1, 1, 1, 1,   4, 4);  // flush with the 4th product
        add(0,   0, 0, 1, 0,   0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].iv, tbl[i].prod, tbl[i].fl, tbl[i].ordy);
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_sum", i), out_sum, tbl[i].esum);
                check($sformatf("tbl%0d_count", i), out_count, tbl[i].ecnt);
            end
        end

        // Backpressure: result held, input stalled, stalled product starts next group
        for (int i = 0; i < 4; i++) step(1, 225, 0, 0);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 7, 0, 0);
            check("bp_hold_sum", out_sum, 900);
            check("bp_in_ready", in_ready, 0);
        end
        step(1, 7, 0, 1);
        check("bp_drained", out_valid, 0);
        step(0, 0, 1, 1);
        check("bp_next_valid", out_valid, 1);
        check("bp_next_sum", out_sum, 7);
        check("bp_next_count", out_count, 1);

        // Back-to-back: drain plus accept in the same cycle
        step(1, 9, 0, 1);
        check("b2b_bubble", out_valid, 0);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        check("b2b_valid", out_valid, 1);
        check("b2b_sum", out_sum, 12);
        check("b2b_count", out_count, 4);
        // Drain plus closing accept keeps HOLD with a fresh one-product result
        step(1, 2, 1, 1);
        check("tp_valid", out_valid, 1);
        check("tp_sum", out_sum, 2);
        check("tp_count", out_count, 1);
        step(0, 0, 0, 1);

        // Asynchronous reset mid-group
        step(1, 50, 0, 1);
        step(1, 60, 0, 1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_sum", out_sum, 0);
        check("arst_count", out_count, 0);
        #1 rst_n = 1'b1;
        m_acc = 0; m_cnt = 0; m_valid = 1'b0; sb.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
        check("arst_next_sum", out_sum, 4);
        check("arst_next_count", out_count, 4);
        step(0, 0, 0, 1);

        // Random soak
        tot_in  = 0;
        tot_out = 0;
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) * $urandom_range(0, 15),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0);
        end
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        check("soak_totals", tot_out, tot_in);
        check("soak_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
